// File: rtl/dram_arbiter.sv
// dram_arbiter: owns the single synchronous data-RAM port and shares it
// between the execute-stage read port and the writeback-stage write port.
// After reset (or a clr pulse) it zeroes every RAM cell before granting any
// access. Writes have priority; a saturating starvation counter lets a
// stalled read win one cycle after STARVE_LIMIT consecutive denials.
//
// Handshake: rd_ce/wr_ce are level requests held by the requester until
// completion. wr_ack is combinational and means "this write commits at the
// end of this cycle". rd_valid is registered and means "the read granted in
// the previous cycle returns its data on rd_d now".
module dram_arbiter #(
  parameter int A_WIDTH      = 12,
  parameter int D_WIDTH      = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  output logic               busy,
  input  logic               rd_ce,
  input  logic [A_WIDTH-1:0] rd_a,
  output logic [D_WIDTH-1:0] rd_d,
  output logic               rd_valid,
  input  logic               wr_ce,
  input  logic [A_WIDTH-1:0] wr_a,
  input  logic [D_WIDTH-1:0] wr_d,
  output logic               wr_ack,
  output logic               ram_ce,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [D_WIDTH-1:0] ram_din,
  input  logic [D_WIDTH-1:0] ram_dout,
  output logic               dbg_state
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [A_WIDTH-1:0] ADDR_LAST = {A_WIDTH{1'b1}};
  localparam logic [3:0]         LIMIT     = 4'(STARVE_LIMIT);

  state_t             state;
  state_t             next_state;
  logic [A_WIDTH-1:0] clr_addr;
  logic [3:0]         starve_cnt;
  logic               rd_grant;
  logic               wr_grant;

  // Read data is the RAM output directly; the requester qualifies it with rd_valid.
  assign rd_d      = ram_dout;
  assign dbg_state = state;

  // Arbitration, RAM port steering and next-state selection.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    wr_ack     = 1'b0;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_a      = '0;
    ram_din    = '0;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    if (reset) begin
      busy = 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          busy    = 1'b1;
          ram_ce  = 1'b1;
          ram_we  = 1'b1;
          ram_a   = clr_addr;
          ram_din = '0;
          if (clr_addr == ADDR_LAST) next_state = RUN;
        end
        RUN: begin
          // A starved read blocks the write for exactly one cycle.
          wr_grant = wr_ce && !(rd_ce && (starve_cnt >= LIMIT));
          rd_grant = rd_ce && !wr_grant;
          if (wr_grant) begin
            ram_ce  = 1'b1;
            ram_we  = 1'b1;
            ram_a   = wr_a;
            ram_din = wr_d;
            wr_ack  = 1'b1;
          end else if (rd_grant) begin
            ram_ce = 1'b1;
            ram_a  = rd_a;
          end
          if (clr) next_state = CLEAR;
        end
        default: next_state = CLEAR;
      endcase
    end
  end

  // State, clear address, starvation counter and read-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      starve_cnt <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state    <= next_state;
      rd_valid <= rd_grant;
      // Wraps to zero naturally after the last cell, ready for the next clear.
      if (state == CLEAR) clr_addr <= clr_addr + A_WIDTH'(1);
      else                clr_addr <= '0;
      if (state == CLEAR || next_state == CLEAR) begin
        starve_cnt <= '0;
      end else if (rd_ce && wr_grant) begin
        if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed testbench for dram_arbiter with a small behavioural RAM model.
module tb_dram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          busy;
  logic          rd_ce;
  logic [AW-1:0] rd_a;
  logic [DW-1:0] rd_d;
  logic          rd_valid;
  logic          wr_ce;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic          wr_ack;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  dram_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .rd_ce(rd_ce), .rd_a(rd_a), .rd_d(rd_d), .rd_valid(rd_valid),
    .wr_ce(wr_ce), .wr_a(wr_a), .wr_d(wr_d), .wr_ack(wr_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_din(ram_din),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous RAM model, one-cycle read latency, preloaded with non-zero junk.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hA0 | 8'(i);
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_a] <= ram_din;
      else        ram_dout   <= mem[ram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well away from the edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; rd_ce = 1'b0; rd_a = '0;
    wr_ce = 1'b0; wr_a = '0; wr_d = '0;
    repeat (3) tick();

    // Reset forces outputs
    wr_ce = 1'b1;
    settle();
    check("rst_busy",   busy,     1);
    check("rst_ram_ce", ram_ce,   0);
    check("rst_wr_ack", wr_ack,   0);
    check("rst_rdv",    rd_valid, 0);
    tick();
    wr_ce = 1'b0;

    // Clear after reset: 16 write cycles of zero to addresses 0..15
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("clr_a",    ram_a,   i);
      check("clr_we",   ram_we,  1);
      check("clr_din",  ram_din, 0);
      check("clr_busy", busy,    1);
      tick();
    end
    settle();
    check("clr_done_busy",  busy,      0);
    check("clr_done_state", dbg_state, 1);

    // Read every cell back through the DUT: all must be zero
    for (int i = 0; i < 16; i++) begin
      rd_ce = 1'b1; rd_a = 4'(i);
      tick();
      settle();
      check("rb_valid", rd_valid, 1);
      check("rb_data",  rd_d,     0);
    end
    rd_ce = 1'b0;
    tick();

    // Preload cell 5 = 0x2A through the write port
    wr_ce = 1'b1; wr_a = 4'd5; wr_d = 8'h2A;
    settle();
    check("pre_ack", wr_ack, 1);
    tick();
    wr_ce = 1'b0;

    // Read latency: grant in N, data in N+1
    rd_ce = 1'b1; rd_a = 4'd5;
    settle();
    check("lat_ram_a",  ram_a,  5);
    check("lat_ram_we", ram_we, 0);
    check("lat_ram_ce", ram_ce, 1);
    tick();
    rd_ce = 1'b0;
    settle();
    check("lat_valid", rd_valid, 1);
    check("lat_data",  rd_d,     8'h2A);
    tick();

    // Collision: write first, then read returns the new data
    rd_ce = 1'b1; rd_a = 4'd7; wr_ce = 1'b1; wr_a = 4'd7; wr_d = 8'h11;
    settle();
    check("col_ack",    wr_ack, 1);
    check("col_we",     ram_we, 1);
    check("col_din",    ram_din, 8'h11);
    tick();
    wr_ce = 1'b0;
    settle();
    check("col_rd_ack", wr_ack,   0);
    check("col_rd_ce",  ram_ce,   1);
    check("col_rd_we",  ram_we,   0);
    check("col_rd_a",   ram_a,    7);
    check("col_rd_rdv", rd_valid, 0);
    tick();
    rd_ce = 1'b0;
    settle();
    check("col_valid", rd_valid, 1);
    check("col_data",  rd_d,     8'h11);
    tick();

    // Starvation: 4 writes, one read, then writes resume
    wr_ce = 1'b1; wr_a = 4'd3; wr_d = 8'h55; rd_ce = 1'b1; rd_a = 4'd2;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stv_wr_ack", wr_ack, 1);
      tick();
    end
    settle();
    check("stv_rd_ack", wr_ack, 0);
    check("stv_rd_we",  ram_we, 0);
    check("stv_rd_a",   ram_a,  2);
    tick();
    settle();
    check("stv_resume", wr_ack,   1);
    check("stv_rdv",    rd_valid, 1);
    check("stv_rd_d",   rd_d,     0);
    tick();
    wr_ce = 1'b0; rd_ce = 1'b0;
    tick();

    // clr in RUN with a read granted in the same cycle
    clr = 1'b1; rd_ce = 1'b1; rd_a = 4'd5;
    settle();
    check("crun_we",   ram_we, 0);
    check("crun_a",    ram_a,  5);
    check("crun_busy", busy,   0);
    tick();
    clr = 1'b0; rd_ce = 1'b0; wr_ce = 1'b1; wr_a = 4'd9; wr_d = 8'h77;
    settle();
    check("crun_rdv",    rd_valid, 1);
    check("crun_rd_d",   rd_d,     8'h2A);
    check("crun_busy1",  busy,     1);
    for (int i = 0; i < 16; i++) begin
      // A clr pulse during CLEAR must not restart the sequence
      clr = (i == 3);
      settle();
      check("crun_wr_ack", wr_ack, 0);
      check("crun_clr_a",  ram_a,  i);
      tick();
    end
    clr = 1'b0;
    settle();
    check("crun_done_busy", busy,   0);
    check("crun_done_ack",  wr_ack, 1);
    tick();
    wr_ce = 1'b0;

    // Reset mid-clear at clr_addr = 9
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    settle();
    check("mid_a9", ram_a, 9);
    tick();
    reset = 1'b1;
    settle();
    check("mid_rst_ce",   ram_ce, 0);
    check("mid_rst_busy", busy,   1);
    tick();
    reset = 1'b0;
    settle();
    check("mid_restart_a", ram_a,    0);
    check("mid_rdv",       rd_valid, 0);
    check("mid_busy",      busy,     1);
    repeat (16) tick();
    settle();
    check("mid_done_busy", busy, 0);

    // The clear really zeroed cell 9 (written with 0x77 earlier)
    rd_ce = 1'b1; rd_a = 4'd9;
    tick();
    rd_ce = 1'b0;
    settle();
    check("final_valid", rd_valid, 1);
    check("final_data",  rd_d,     0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
